// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the mip32 fetch/data requesters, the memory port arbiter
// and the single-ported unified memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // The arbiter sits on the slave side; requesters and memory form the master side.
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_ack, if_rdata,
        output d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_ack, if_rdata,
        input  d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the mip32 fetch and data requesters onto one fixed-latency memory;
// data has priority, a streak counter keeps fetch from starving.
module mem_port_arbiter #(
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 32,
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);

    localparam int LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [LAT_W-1:0]    wait_cnt;
    logic [STREAK_W-1:0] streak;
    logic                owner_fetch;
    logic                grant_data;
    logic                grant_fetch;
    logic                wait_last;
    logic                streak_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Data wins unless fetch is waiting and data has already used up its streak.
    always_comb begin
        state_next  = state;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        streak_full = (streak == STREAK_W'(MAX_DATA_STREAK));
        wait_last   = (wait_cnt == LAT_W'(MEM_LATENCY - 1));
        case (state)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && streak_full)) begin
                    grant_data = 1'b1;
                end else if (bus.if_req) begin
                    grant_fetch = 1'b1;
                end
                if (grant_data || grant_fetch) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (wait_last) begin
                    state_next = RESP;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Every output is a flop; the request fields are frozen into mem_* at the grant edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_rdata   <= '0;
            busy          <= 1'b0;
            wait_cnt      <= '0;
            streak        <= '0;
            owner_fetch   <= 1'b0;
        end else begin
            bus.mem_en <= grant_data || grant_fetch;
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            busy       <= (state_next != IDLE);

            if (grant_data) begin
                bus.mem_addr  <= bus.d_addr;
                bus.mem_we    <= bus.d_we;
                bus.mem_wdata <= bus.d_wdata;
                owner_fetch   <= 1'b0;
                if (!bus.if_req) begin
                    streak <= '0;
                end else if (!streak_full) begin
                    streak <= streak + STREAK_W'(1);
                end
            end else if (grant_fetch) begin
                bus.mem_addr  <= bus.if_addr;
                bus.mem_we    <= 1'b0;
                bus.mem_wdata <= '0;
                owner_fetch   <= 1'b1;
                streak        <= '0;
            end

            if (state == WAIT) begin
                wait_cnt <= wait_cnt + LAT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            // Read data is valid on the last WAIT cycle, so ack and rdata land together in RESP.
            if ((state == WAIT) && wait_last) begin
                if (owner_fetch) begin
                    bus.if_ack   <= 1'b1;
                    bus.if_rdata <= bus.mem_rdata;
                end else begin
                    bus.d_ack <= 1'b1;
                    if (!bus.mem_we) begin
                        bus.d_rdata <= bus.mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural fixed-latency memory
// plus an ack monitor that pops expected responses in order.
module tb_mem_port_arbiter;

    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 32;
    localparam int MEM_LATENCY     = 2;
    localparam int MAX_DATA_STREAK = 4;

    typedef struct {
        bit          is_fetch;
        bit          is_write;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_if_rdata = '0;
    logic [31:0] model_d_rdata = '0;

    logic [31:0] mem_store   [0:255];
    bit          mem_written [0:255];
    logic [31:0] rd_pipe     [0:MEM_LATENCY-1];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MEM_LATENCY(MEM_LATENCY),
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [7:0] a);
        case (a)
            8'h04:   return 32'h0BADF00D;
            8'h08:   return 32'h12345678;
            8'h10:   return 32'h2002000A;
            8'h30:   return 32'h30303030;
            8'h34:   return 32'h34343434;
            default: return {24'hA5A5A5, a};
        endcase
    endfunction

    // Memory model: read data appears MEM_LATENCY cycles after the mem_en cycle.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            rd_pipe[0] <= mem_written[bus.mem_addr] ? mem_store[bus.mem_addr] : init_word(bus.mem_addr);
        end else begin
            rd_pipe[0] <= 32'hBAD0BAD0;
        end
        for (int i = 1; i < MEM_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
        if (bus.mem_en && bus.mem_we) begin
            mem_store[bus.mem_addr]   <= bus.mem_wdata;
            mem_written[bus.mem_addr] <= 1'b1;
        end
    end

    assign bus.mem_rdata = rd_pipe[MEM_LATENCY-1];

    // Ack monitor: each ack must match the oldest expected response.
    always @(negedge clk) begin
        if (!reset && (bus.if_ack || bus.d_ack)) begin
            checks++;
            if (bus.if_ack && bus.d_ack) begin
                errors++;
                $display("[TB] FAIL dual_ack: if_ack=1 d_ack=1, required at most one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_ack: if_ack=%0b d_ack=%0b, required no ack", bus.if_ack, bus.d_ack);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.if_ack !== mon_e.is_fetch) begin
                    errors++;
                    $display("[TB] FAIL ack_owner: if_ack=%0b, required %0b", bus.if_ack, mon_e.is_fetch);
                end else if (mon_e.is_fetch) begin
                    checks++;
                    if (bus.if_rdata !== mon_e.data) begin
                        errors++;
                        $display("[TB] FAIL if_rdata: got %h, required %h", bus.if_rdata, mon_e.data);
                    end
                    model_if_rdata = mon_e.data;
                    checks++;
                    if (bus.d_rdata !== model_d_rdata) begin
                        errors++;
                        $display("[TB] FAIL d_rdata_hold_on_fetch: got %h, required %h", bus.d_rdata, model_d_rdata);
                    end
                end else begin
                    checks++;
                    if (mon_e.is_write) begin
                        if (bus.d_rdata !== model_d_rdata) begin
                            errors++;
                            $display("[TB] FAIL d_rdata_hold_on_write: got %h, required %h", bus.d_rdata, model_d_rdata);
                        end
                    end else begin
                        if (bus.d_rdata !== mon_e.data) begin
                            errors++;
                            $display("[TB] FAIL d_rdata: got %h, required %h", bus.d_rdata, mon_e.data);
                        end
                        model_d_rdata = mon_e.data;
                    end
                    checks++;
                    if (bus.if_rdata !== model_if_rdata) begin
                        errors++;
                        $display("[TB] FAIL if_rdata_hold_on_data: got %h, required %h", bus.if_rdata, model_if_rdata);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        model_if_rdata = '0;
        model_d_rdata  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.if_ack, bus.d_ack, busy} !== 5'b0 ||
            bus.mem_addr !== '0 || bus.mem_wdata !== '0 ||
            bus.if_rdata !== '0 || bus.d_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: en=%0b we=%0b ia=%0b da=%0b busy=%0b addr=%h wd=%h ir=%h dr=%h, required all 0",
                     bus.mem_en, bus.mem_we, bus.if_ack, bus.d_ack, busy,
                     bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
        end
        do_reset();
    endtask

    task automatic test_single_fetch();
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h10;
        exp_q.push_back('{1'b1, 1'b0, 32'h2002000A});
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (bus.mem_en !== (c == 1)) begin
                errors++;
                $display("[TB] FAIL fetch_mem_en c%0d: got %0b, required %0b", c, bus.mem_en, (c == 1));
            end
            checks++;
            if (busy !== (c <= 4)) begin
                errors++;
                $display("[TB] FAIL fetch_busy c%0d: got %0b, required %0b", c, busy, (c <= 4));
            end
            checks++;
            if (bus.if_ack !== (c == 4)) begin
                errors++;
                $display("[TB] FAIL fetch_if_ack c%0d: got %0b, required %0b", c, bus.if_ack, (c == 4));
            end
            if (c == 1) begin
                checks++;
                if (bus.mem_addr !== 8'h10 || bus.mem_we !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL fetch_issue: addr=%h we=%0b, required addr=10 we=0", bus.mem_addr, bus.mem_we);
                end
            end
            if (c == 4) begin
                bus.if_req = 1'b0;
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h04;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 8'h20;
        bus.d_wdata = 32'hDEADBEEF;
        exp_q.push_back('{1'b0, 1'b1, 32'h0});
        exp_q.push_back('{1'b1, 1'b0, 32'h0BADF00D});
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) begin
                checks++;
                if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h20 || bus.mem_wdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("[TB] FAIL simul_data_issue: en=%0b we=%0b addr=%h wd=%h, required 1 1 20 deadbeef",
                             bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            checks++;
            if (bus.d_ack !== (c == 4)) begin
                errors++;
                $display("[TB] FAIL simul_d_ack c%0d: got %0b, required %0b", c, bus.d_ack, (c == 4));
            end
            if (c == 4) begin
                bus.d_req = 1'b0;
                bus.d_we  = 1'b0;
            end
            checks++;
            if (bus.mem_en !== (c == 1 || c == 6)) begin
                errors++;
                $display("[TB] FAIL simul_mem_en c%0d: got %0b, required %0b", c, bus.mem_en, (c == 1 || c == 6));
            end
            if (c == 6) begin
                checks++;
                if (bus.mem_addr !== 8'h04 || bus.mem_we !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL simul_fetch_issue: addr=%h we=%0b, required 04 0", bus.mem_addr, bus.mem_we);
                end
            end
            checks++;
            if (bus.if_ack !== (c == 9)) begin
                errors++;
                $display("[TB] FAIL simul_if_ack c%0d: got %0b, required %0b", c, bus.if_ack, (c == 9));
            end
            if (c == 9) begin
                bus.if_req = 1'b0;
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_idle_busy: got %0b, required 0", busy);
        end
    endtask

    task automatic test_data_read();
        logic [7:0]  addrs [2];
        logic [31:0] datas [2];
        addrs = '{8'h08, 8'h20};
        datas = '{32'h12345678, 32'hDEADBEEF};
        for (int t = 0; t < 2; t++) begin
            bus.d_req  = 1'b1;
            bus.d_we   = 1'b0;
            bus.d_addr = addrs[t];
            exp_q.push_back('{1'b0, 1'b0, datas[t]});
            for (int c = 1; c <= 5; c++) begin
                step();
                checks++;
                if (bus.if_ack !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL read_no_if_ack c%0d: got %0b, required 0", c, bus.if_ack);
                end
                if (c == 1) begin
                    checks++;
                    if (bus.mem_en !== 1'b1 || bus.mem_addr !== addrs[t] || bus.mem_we !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL read_issue: en=%0b addr=%h we=%0b, required 1 %h 0",
                                 bus.mem_en, bus.mem_addr, bus.mem_we, addrs[t]);
                    end
                end
                if (c == 4) begin
                    checks++;
                    if (bus.d_ack !== 1'b1 || bus.d_rdata !== datas[t] || bus.if_rdata !== 32'h0BADF00D) begin
                        errors++;
                        $display("[TB] FAIL read_resp: ack=%0b d_rdata=%h if_rdata=%h, required 1 %h 0badf00d",
                                 bus.d_ack, bus.d_rdata, bus.if_rdata, datas[t]);
                    end
                    bus.d_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_addr_capture();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 8'h30;
        exp_q.push_back('{1'b0, 1'b0, 32'h30303030});
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) begin
                bus.d_addr  = 8'h34;
                bus.d_we    = 1'b1;
                bus.d_wdata = 32'h11111111;
            end
            if (c == 2) begin
                checks++;
                if (bus.mem_addr !== 8'h30 || bus.mem_we !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL capture_addr: addr=%h we=%0b, required 30 0", bus.mem_addr, bus.mem_we);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h30303030) begin
                    errors++;
                    $display("[TB] FAIL capture_resp: ack=%0b d_rdata=%h, required 1 30303030", bus.d_ack, bus.d_rdata);
                end
                bus.d_req = 1'b0;
                bus.d_we  = 1'b0;
            end
        end
    endtask

    task automatic test_streak();
        bit pattern [10];
        int n = 0;
        bit got_fetch;
        pattern = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h40;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'h80;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back('{pattern[i], 1'b0, pattern[i] ? 32'hA5A5A540 : 32'hA5A5A580});
        end
        for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
            step();
            if (bus.mem_en) begin
                got_fetch = (bus.mem_addr == 8'h40);
                checks++;
                if (got_fetch !== pattern[n]) begin
                    errors++;
                    $display("[TB] FAIL streak_grant_%0d: got %s, required %s", n,
                             got_fetch ? "I" : "D", pattern[n] ? "I" : "D");
                end
                n++;
            end
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("[TB] FAIL streak_timeout: saw %0d grants, required 10", n);
        end
        step();
        step();
        step();
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL streak_idle_busy: got %0b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h10;
        step();
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_en !== 1'b0 || busy !== 1'b0 || bus.if_ack !== 1'b0 || bus.d_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: en=%0b busy=%0b ia=%0b da=%0b, required all 0",
                     bus.mem_en, busy, bus.if_ack, bus.d_ack);
        end
        step();
        reset = 1'b0;
        exp_q.push_back('{1'b1, 1'b0, 32'h2002000A});
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (bus.mem_en !== (c == 1)) begin
                errors++;
                $display("[TB] FAIL reissue_mem_en c%0d: got %0b, required %0b", c, bus.mem_en, (c == 1));
            end
            checks++;
            if (bus.if_ack !== (c == 4)) begin
                errors++;
                $display("[TB] FAIL reissue_if_ack c%0d: got %0b, required %0b", c, bus.if_ack, (c == 4));
            end
            if (c == 4) begin
                bus.if_req = 1'b0;
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_data_read();
        test_addr_capture();
        test_streak();
        test_reset_mid_access();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
